// File: rtl/pdm_adpcm_multi.sv
// Multi-channel PDM front end: per-channel order-2 CIC decimators feeding one shared IMA ADPCM encoder.
// Codes leave channel by channel over a valid/ready port; a batch that arrives while the encoder is busy is dropped and flagged.
module pdm_adpcm_multi #(
  parameter int N_CH  = 2,
  parameter int LOG2R = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            pdm_stb,
  input  logic [N_CH-1:0] pdm_in,
  output logic            code_valid,
  input  logic            code_ready,
  output logic [3:0]      code,
  output logic [1:0]      code_ch,
  output logic [15:0]     pcm,
  output logic            overrun
);

  localparam int         W       = 2*LOG2R + 1;
  localparam int         SHIFT   = 16 - 2*LOG2R;
  localparam logic [1:0] LAST_CH = 2'(N_CH - 1);

  localparam logic [14:0] STEP_TAB [89] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,    15'd16,    15'd17,
    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,    15'd34,    15'd37,    15'd41,    15'd45,
    15'd50,    15'd55,    15'd60,    15'd66,    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,
    15'd130,   15'd143,   15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,   15'd724,   15'd796,
    15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,  15'd1552,  15'd1707,  15'd1878,  15'd2066,
    15'd2272,  15'd2499,  15'd2749,  15'd3024,  15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,
    15'd5894,  15'd6484,  15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794, 15'd32767
  };

  typedef enum logic [1:0] {IDLE, ENC, HOLD} state_t;
  state_t state, state_d;

  logic             acc_stb, batch_done;
  logic [LOG2R-1:0] dec_cnt;
  logic [W-1:0]     integ1 [N_CH];
  logic [W-1:0]     integ2 [N_CH];
  logic [W-1:0]     comb_d1 [N_CH];
  logic [W-1:0]     comb_d2 [N_CH];
  logic [W-1:0]     integ2_nx [N_CH];
  logic [W-1:0]     comb1 [N_CH];
  logic [W-1:0]     comb2 [N_CH];
  logic [W-1:0]     batch_c [N_CH];
  logic [1:0]       cur_ch;
  logic signed [15:0] pred_r [N_CH];
  logic [6:0]       idx_r [N_CH];

  assign acc_stb    = ena & pdm_stb;
  assign batch_done = acc_stb && (dec_cnt == '1);
  assign code_valid = (state == HOLD);

  // Modular W-bit arithmetic is exact because the comb output never exceeds R^2.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      integ2_nx[i] = integ2[i] + integ1[i];
      comb1[i]     = integ2_nx[i] - comb_d1[i];
      comb2[i]     = comb1[i] - comb_d2[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
      for (int i = 0; i < N_CH; i++) begin
        integ1[i]  <= '0;
        integ2[i]  <= '0;
        comb_d1[i] <= '0;
        comb_d2[i] <= '0;
      end
    end else if (acc_stb) begin
      dec_cnt <= dec_cnt + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        integ1[i] <= integ1[i] + W'(pdm_in[i]);
        integ2[i] <= integ2_nx[i];
        if (batch_done) begin
          comb_d1[i] <= integ2_nx[i];
          comb_d2[i] <= comb1[i];
        end
      end
    end
  end

  logic [W-1:0]       sel_c;
  logic signed [15:0] sel_pred, pred_new;
  logic [6:0]         sel_idx, idx_new;
  logic [16:0]        scaled, mag, mag1, mag2, step, diffq;
  logic [15:0]        enc_pcm;
  logic signed [16:0] diff;
  logic signed [17:0] pred_x, dq_x, pred_sum;
  logic signed [7:0]  idx_adj, idx_sum;
  logic               sgn, b2, b1, b0;
  logic [3:0]         enc_code;

  always_comb begin
    sel_c    = '0;
    sel_pred = '0;
    sel_idx  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur_ch == 2'(i)) begin
        sel_c    = batch_c[i];
        sel_pred = pred_r[i];
        sel_idx  = idx_r[i];
      end
    end
    // Full scale R^2 lands on 65536 after the shift and is pinned to +32767.
    scaled  = 17'(sel_c) << SHIFT;
    enc_pcm = scaled[16] ? 16'h7fff : {~scaled[15], scaled[14:0]};
    diff    = $signed({enc_pcm[15], enc_pcm}) - $signed({sel_pred[15], sel_pred});
    sgn     = diff[16];
    mag     = sgn ? 17'(-diff) : 17'(diff);
    step    = 17'(STEP_TAB[sel_idx]);
    b2      = (mag >= step);
    mag1    = b2 ? mag - step : mag;
    b1      = (mag1 >= (step >> 1));
    mag2    = b1 ? mag1 - (step >> 1) : mag1;
    b0      = (mag2 >= (step >> 2));
    diffq   = (step >> 3) + (b2 ? step : '0) + (b1 ? (step >> 1) : '0) + (b0 ? (step >> 2) : '0);
    pred_x  = {{2{sel_pred[15]}}, sel_pred};
    dq_x    = {1'b0, diffq};
    pred_sum = sgn ? pred_x - dq_x : pred_x + dq_x;
    if (pred_sum > 18'sd32767)       pred_new = 16'sh7fff;
    else if (pred_sum < -18'sd32768) pred_new = 16'sh8000;
    else                             pred_new = pred_sum[15:0];
    enc_code = {sgn, b2, b1, b0};
    case ({b2, b1, b0})
      3'd4:    idx_adj = 8'sd2;
      3'd5:    idx_adj = 8'sd4;
      3'd6:    idx_adj = 8'sd6;
      3'd7:    idx_adj = 8'sd8;
      default: idx_adj = -8'sd1;
    endcase
    idx_sum = $signed({1'b0, sel_idx}) + idx_adj;
    if (idx_sum < 8'sd0)       idx_new = 7'd0;
    else if (idx_sum > 8'sd88) idx_new = 7'd88;
    else                       idx_new = idx_sum[6:0];
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (batch_done) state_d = ENC;
      ENC:     if (ena) state_d = HOLD;
      HOLD:    if (code_ready) state_d = (cur_ch == LAST_CH) ? IDLE : ENC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch  <= '0;
      code    <= '0;
      code_ch <= '0;
      pcm     <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        batch_c[i] <= '0;
        pred_r[i]  <= '0;
        idx_r[i]   <= '0;
      end
    end else begin
      if (batch_done) begin
        if (state == IDLE) begin
          cur_ch <= '0;
          for (int i = 0; i < N_CH; i++) batch_c[i] <= comb2[i];
        end else begin
          overrun <= 1'b1;
        end
      end
      // Channel state advances here whether or not the sink is ready.
      if (state == ENC && ena) begin
        code    <= enc_code;
        code_ch <= cur_ch;
        pcm     <= enc_pcm;
        for (int i = 0; i < N_CH; i++) begin
          if (cur_ch == 2'(i)) begin
            pred_r[i] <= pred_new;
            idx_r[i]  <= idx_new;
          end
        end
      end
      if (state == HOLD && code_ready && cur_ch != LAST_CH) cur_ch <= cur_ch + 2'd1;
    end
  end

endmodule

// File: tb/tb_pdm_adpcm_multi.sv
// Directed bench for pdm_adpcm_multi (4 channels, R=16) with a CIC/IMA reference model and expected-code queue.
module tb_pdm_adpcm_multi;

  localparam int N_CH  = 4;
  localparam int LOG2R = 4;
  localparam int R     = 1 << LOG2R;

  logic        clk = 1'b0;
  logic        rst_n, ena, pdm_stb, code_ready;
  logic [3:0]  pdm_in;
  logic        code_valid, overrun;
  logic [3:0]  code;
  logic [1:0]  code_ch;
  logic [15:0] pcm;

  always #5 clk = ~clk;

  pdm_adpcm_multi #(.N_CH(N_CH), .LOG2R(LOG2R)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pdm_stb(pdm_stb), .pdm_in(pdm_in),
    .code_valid(code_valid), .code_ready(code_ready), .code(code),
    .code_ch(code_ch), .pcm(pcm), .overrun(overrun)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int STEP_TAB [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  int IDXT [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  typedef struct packed {
    logic [3:0]  code;
    logic [1:0]  ch;
    logic [15:0] pcm;
  } exp_t;
  exp_t sbq [$];

  // Reference state: running first/second sums of the bit stream and the encoder state.
  longint s1 [N_CH];
  longint y [N_CH];
  longint yb1 [N_CH];
  longint yb2 [N_CH];
  int     pred_m [N_CH];
  int     idx_m [N_CH];
  int     nstb, seq_n, mode;
  bit     drop_next;

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      s1[ch] = 0; y[ch] = 0; yb1[ch] = 0; yb2[ch] = 0; pred_m[ch] = 0; idx_m[ch] = 0;
    end
    nstb = 0; seq_n = 0; drop_next = 0;
    sbq.delete();
  endtask

  task automatic model_encode(input int ch, input int c);
    int pcm_v, step, diff, code_v, vpd;
    exp_t e;
    pcm_v = (c >= R*R) ? 32767 : c * (1 << (16 - 2*LOG2R)) - 32768;
    step = STEP_TAB[idx_m[ch]];
    diff = pcm_v - pred_m[ch];
    code_v = 0;
    if (diff < 0) begin code_v = 8; diff = -diff; end
    vpd = step >> 3;
    if (diff >= step) begin code_v |= 4; diff -= step; vpd += step; end
    step = step >> 1;
    if (diff >= step) begin code_v |= 2; diff -= step; vpd += step; end
    step = step >> 1;
    if (diff >= step) begin code_v |= 1; vpd += step; end
    pred_m[ch] = ((code_v & 8) != 0) ? pred_m[ch] - vpd : pred_m[ch] + vpd;
    if (pred_m[ch] > 32767) pred_m[ch] = 32767;
    if (pred_m[ch] < -32768) pred_m[ch] = -32768;
    idx_m[ch] += IDXT[code_v & 7];
    if (idx_m[ch] < 0) idx_m[ch] = 0;
    if (idx_m[ch] > 88) idx_m[ch] = 88;
    e.code = 4'(code_v);
    e.ch   = 2'(ch);
    e.pcm  = 16'(pcm_v);
    sbq.push_back(e);
  endtask

  // CIC output of a batch is the second difference of the double running sum at batch boundaries.
  task automatic model_accept(input logic [3:0] bits);
    longint c;
    for (int ch = 0; ch < N_CH; ch++) begin
      y[ch]  += s1[ch];
      s1[ch] += longint'(bits[ch]);
    end
    nstb++;
    if (nstb % R == 0) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        c = y[ch] - 2*yb1[ch] + yb2[ch];
        yb2[ch] = yb1[ch];
        yb1[ch] = y[ch];
        if (!drop_next) model_encode(ch, int'(c));
      end
      drop_next = 0;
    end
  endtask

  function automatic logic [3:0] pat_bits(input int n);
    logic alt;
    alt = (n % 2 == 0);
    if (mode == 0) return {alt, alt, 1'b0, 1'b1};
    return {4{alt}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [3:0] bits, input logic en);
    ena = en; pdm_stb = 1'b1; pdm_in = bits;
    if (en) model_accept(bits);
    tick();
    pdm_stb = 1'b0;
  endtask

  task automatic run(input int cnt, input logic en);
    for (int i = 0; i < cnt; i++) begin
      strobe(en ? pat_bits(seq_n) : ~pat_bits(seq_n), en);
      if (en) seq_n++;
      idle(1);
    end
  endtask

  int cyc = 0, last_acc = 0;
  bit gap_chk = 1;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (code_valid && code_ready) begin
      check("sb_has_entry", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("code", code, e.code);
        check("code_ch", code_ch, e.ch);
        check("pcm", pcm, e.pcm);
        if (gap_chk && e.ch != 0) check("ch_gap", cyc - last_acc, 2);
      end
      last_acc = cyc;
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; pdm_stb = 1'b0; pdm_in = '0; code_ready = 1'b1; mode = 0;
    model_reset();
    idle(2);
    check("rst_valid", code_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_code_ch", code_ch, 0);
    check("rst_code", code, 0);
    check("rst_pcm", pcm, 0);
    rst_n = 1'b1;

    // Channel order and signs: ch0 ones, ch1 zeros, ch2/ch3 alternating.
    run(R-1, 1'b1);
    strobe(pat_bits(seq_n), 1'b1);
    seq_n++;
    check("lat_cycle1", code_valid, 0);
    idle(1);
    check("lat_cycle2", code_valid, 1);
    check("lat_ch0", code_ch, 0);
    run(4*R, 1'b1);
    idle(10);

    // Backpressure: one batch held, the next one dropped.
    code_ready = 1'b0;
    run(R, 1'b1);
    idle(1);
    check("bp_valid", code_valid, 1);
    check("bp_no_overrun", overrun, 0);
    check("bp_code", code, sbq[0].code);
    check("bp_code_ch", code_ch, sbq[0].ch);
    drop_next = 1;
    run(R, 1'b1);
    idle(2);
    check("bp_overrun", overrun, 1);
    check("bp_valid_held", code_valid, 1);
    check("bp_code_stable", code, sbq[0].code);
    check("bp_ch_stable", code_ch, sbq[0].ch);
    check("bp_pcm_stable", pcm, sbq[0].pcm);
    code_ready = 1'b1;
    run(2*R, 1'b1);
    idle(10);
    check("bp_overrun_sticky", overrun, 1);

    // ena gap mid-batch with different bits during the gap.
    run(5, 1'b1);
    run(10, 1'b0);
    run(1, 1'b1);
    idle(2);
    check("gap_no_batch", code_valid, 0);
    run(R-6, 1'b1);
    idle(10);

    // ena low while holding: valid stays up and the handshake still completes.
    code_ready = 1'b0;
    run(R, 1'b1);
    idle(2);
    ena = 1'b0;
    idle(3);
    check("ena_hold_valid", code_valid, 1);
    check("ena_hold_ch", code_ch, 0);
    check("ena_hold_code", code, sbq[0].code);
    gap_chk = 0;
    code_ready = 1'b1;
    idle(3);
    ena = 1'b1;
    idle(10);
    gap_chk = 1;

    // Reset while ch1 is held.
    run(R-1, 1'b1);
    strobe(pat_bits(seq_n), 1'b1);
    seq_n++;
    idle(2);
    code_ready = 1'b0;
    idle(1);
    check("pre_rst_valid", code_valid, 1);
    check("pre_rst_ch", code_ch, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", code_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_code_ch", code_ch, 0);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    code_ready = 1'b1;

    // Alternating input on all channels after reset.
    mode = 1;
    run(R-1, 1'b1);
    idle(3);
    check("post_rst_no_code", code_valid, 0);
    run(4*R+1, 1'b1);
    idle(10);
    check("alt_overrun", overrun, 0);
    check("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
